// File: rtl/maxpool_pkg.sv
// Shared types, default sizing and helpers for the maxpool reduction block.
// Optional fused ReLU in maxpool_reduce is enabled with MAXPOOL_REDUCE_RELU_EN.
package maxpool_pkg;

  localparam int unsigned MP_DATA_WIDTH   = 16;
  localparam int unsigned MP_IMAGE_WIDTH  = 188;
  localparam int unsigned MP_IMAGE_HEIGHT = 120;
  localparam int unsigned MP_OUT_CHANNELS = 16;
  localparam int unsigned MP_STRIDE       = 2;
  localparam int unsigned MP_FIFO_DEPTH   = 8;

  // Pooled dimension, rounding up so a padded odd column/row still yields an output
  function automatic int unsigned out_dim(input int unsigned n, input int unsigned s);
    return (n + s - 1) / s;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OUT_W = out_dim(MP_IMAGE_WIDTH, MP_STRIDE);
  localparam int unsigned OUT_H = out_dim(MP_IMAGE_HEIGHT, 2);

  typedef logic signed [MP_DATA_WIDTH-1:0] pixel_t;

  typedef struct packed {
    logic [idx_w(MP_OUT_CHANNELS)-1:0] ch;
    logic [idx_w(OUT_W)-1:0]           col;
    logic [idx_w(OUT_H)-1:0]           row;
    logic                              last_col;
    logic                              frame_done;
  } pool_tag_t;

  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_out_fifo.sv
// Synchronous FIFO holding pooled results; a push at full is accepted only alongside a pop.
module maxpool_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_en;
  logic             pop_en;

  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_en   = pop && !empty_c;
    push_en  = push && (!full_c || pop_en);
    wr_ptr_d = push_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rdata_c  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the read side is qualified by empty_c
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/maxpool_reduce.sv
// 2x2 signed max reduction with position tagging and an output FIFO for backpressure.
// Define MAXPOOL_REDUCE_RELU_EN to clamp negative results to zero in stage 2.
module maxpool_reduce
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = MP_DATA_WIDTH,
  parameter int unsigned IMAGE_WIDTH  = MP_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = MP_IMAGE_HEIGHT,
  parameter int unsigned OUT_CHANNELS = MP_OUT_CHANNELS,
  parameter int unsigned STRIDE       = MP_STRIDE,
  parameter int unsigned FIFO_DEPTH   = MP_FIFO_DEPTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  input  logic [1:0][1:0][DATA_WIDTH-1:0]              in_window,
  input  logic                                         out_ready,
  output logic                                         out_valid,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic [idx_w(OUT_CHANNELS)-1:0]               out_ch,
  output logic [idx_w(out_dim(IMAGE_WIDTH, STRIDE))-1:0] out_col,
  output logic [idx_w(out_dim(IMAGE_HEIGHT, 2))-1:0]   out_row,
  output logic                                         out_last_col,
  output logic                                         out_frame_done,
  output logic                                         overflow
);

  localparam int unsigned OW = out_dim(IMAGE_WIDTH, STRIDE);
  localparam int unsigned OH = out_dim(IMAGE_HEIGHT, 2);
  localparam int unsigned CW = idx_w(OUT_CHANNELS);
  localparam int unsigned XW = idx_w(OW);
  localparam int unsigned YW = idx_w(OH);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          last_col;
    logic          frame_done;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [CW-1:0] ch_q, ch_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  tag_t          in_tag;

  logic                         s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0] s1_m0_q, s1_m0_d;
  logic signed [DATA_WIDTH-1:0] s1_m1_q, s1_m1_d;
  tag_t                         s1_tag_q, s1_tag_d;

  logic                         s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  tag_t                         s2_tag_q, s2_tag_d;

  logic overflow_q, overflow_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_rdata;
  entry_t        fifo_wdata;
  entry_t        head;

  // Position counters advance only on accepted windows: channel, then column, then row
  always_comb begin
    ch_d  = ch_q;
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (ch_q == CW'(OUT_CHANNELS - 1)) begin
        ch_d = '0;
        if (col_q == XW'(OW - 1)) begin
          col_d = '0;
          row_d = (row_q == YW'(OH - 1)) ? '0 : row_q + YW'(1);
        end else begin
          col_d = col_q + XW'(1);
        end
      end else begin
        ch_d = ch_q + CW'(1);
      end
    end
  end

  always_comb begin
    in_tag            = '0;
    in_tag.ch         = ch_q;
    in_tag.col        = col_q;
    in_tag.row        = row_q;
    in_tag.last_col   = (col_q == XW'(OW - 1)) && (ch_q == CW'(OUT_CHANNELS - 1));
    in_tag.frame_done = in_tag.last_col && (row_q == YW'(OH - 1));
  end

  // Stage 1: row-wise max of each window row
  always_comb begin
    s1_valid_d = in_valid;
    s1_tag_d   = in_tag;
    s1_m0_d    = ($signed(in_window[0][0]) >= $signed(in_window[0][1])) ?
                 $signed(in_window[0][0]) : $signed(in_window[0][1]);
    s1_m1_d    = ($signed(in_window[1][0]) >= $signed(in_window[1][1])) ?
                 $signed(in_window[1][0]) : $signed(in_window[1][1]);
  end

  // Stage 2: final max, optionally rectified
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_data_d  = (s1_m0_q >= s1_m1_q) ? s1_m0_q : s1_m1_q;
`ifdef MAXPOOL_REDUCE_RELU_EN
    if (s2_data_d[DATA_WIDTH-1]) s2_data_d = '0;
`endif
  end

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.data = s2_data_q;
    fifo_wdata.tag  = s2_tag_q;
    fifo_pop        = !fifo_empty && out_ready;
    overflow_d      = overflow_q || (s2_valid_q && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_m0_q    <= '0;
      s1_m1_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      col_q      <= col_d;
      row_q      <= row_d;
      s1_valid_q <= s1_valid_d;
      s1_m0_q    <= s1_m0_d;
      s1_m1_q    <= s1_m1_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      overflow_q <= overflow_d;
    end
  end

  maxpool_out_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s2_valid_q),
    .pop     (fifo_pop),
    .wdata   (fifo_wdata),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Head fields read as zero whenever nothing is queued
  always_comb begin
    head           = fifo_empty ? '0 : fifo_rdata;
    out_valid      = !fifo_empty;
    out_data       = head.data;
    out_ch         = head.tag.ch;
    out_col        = head.tag.col;
    out_row        = head.tag.row;
    out_last_col   = head.tag.last_col;
    out_frame_done = head.tag.frame_done;
    overflow       = overflow_q;
  end

endmodule

// File: tb/tb_maxpool_reduce.sv
// Directed scoreboard bench for maxpool_reduce on a 6x4 image, 2 channels, 4-entry FIFO.
module tb_maxpool_reduce;

  localparam int unsigned DW = 16;
  localparam int unsigned OC = 2;
  localparam int unsigned OW = 3;
  localparam int unsigned OH = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [0:0]    ch;
    logic [1:0]    col;
    logic [0:0]    row;
    logic          last;
    logic          done;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [1:0][1:0][DW-1:0] in_window;
  logic                   out_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [0:0]             out_ch;
  logic [1:0]             out_col;
  logic [0:0]             out_row;
  logic                   out_last_col;
  logic                   out_frame_done;
  logic                   overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   idx   = 0;
  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_obs;

  maxpool_reduce #(
    .DATA_WIDTH   (DW),
    .IMAGE_WIDTH  (6),
    .IMAGE_HEIGHT (4),
    .OUT_CHANNELS (OC),
    .STRIDE       (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_window      (in_window),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ch         (out_ch),
    .out_col        (out_col),
    .out_row        (out_row),
    .out_last_col   (out_last_col),
    .out_frame_done (out_frame_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic signed [DW-1:0] ref_max(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b,
                                                   input logic signed [DW-1:0] c,
                                                   input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
`ifdef MAXPOOL_REDUCE_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one window for a cycle; keep=0 marks a result the FIFO is expected to drop
  task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                      input bit keep);
    exp_t e;
    int   ch, col, row;
    ch  = idx % OC;
    col = (idx / OC) % OW;
    row = (idx / (OC * OW)) % OH;
    e.data = ref_max(a, b, c, d);
    e.ch   = 1'(ch);
    e.col  = 2'(col);
    e.row  = 1'(row);
    e.last = (col == OW - 1) && (ch == OC - 1);
    e.done = e.last && (row == OH - 1);
    idx = idx + 1;
    if (keep) sb.push_back(e);
    in_window[0][0] = a;
    in_window[0][1] = b;
    in_window[1][0] = c;
    in_window[1][1] = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit keep);
    send(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), keep);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    idx = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk(tag, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every handshaken head must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid && out_ready) begin
      mon_obs = {out_data, out_ch, out_col, out_row, out_last_col, out_frame_done};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_output observed data=%0d expected none", $signed(out_data));
      end else begin
        mon_exp = sb.pop_front();
        assert (mon_obs === mon_exp) else begin
          n_err++;
          $error("FAIL sb_entry observed d=%0d ch=%0d col=%0d row=%0d last=%0b done=%0b expected d=%0d ch=%0d col=%0d row=%0d last=%0b done=%0b",
                 $signed(mon_obs.data), mon_obs.ch, mon_obs.col, mon_obs.row, mon_obs.last, mon_obs.done,
                 $signed(mon_exp.data), mon_exp.ch, mon_exp.col, mon_exp.row, mon_exp.last, mon_exp.done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] head0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_window = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_tags",  32'({out_ch, out_col, out_row, out_last_col, out_frame_done}), 32'd0);
    @(posedge clk); #1;

    // Signed max and latency
    out_ready = 1'b1;
    send(-16'sd5, 16'sd3, 16'sd7, -16'sd32768, 1'b1);
    @(negedge clk); chk("lat_n1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_n2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_n3", 32'(out_valid), 32'd1);
    chk("smax_data", 32'(out_data), 32'd7);
    chk("smax_tag",  32'({out_ch, out_col, out_row}), 32'd0);
    @(negedge clk); chk("lat_n4", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // All-negative window
    send(-16'sd1, -16'sd2, -16'sd3, -16'sd4, 1'b1);
    drain("drain_neg");

    // Full frame plus first output of the next frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) send_rand(1'b1);
    drain("drain_frame");

    // Backpressure into a 4-entry FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(1'b1);
    repeat (4) @(negedge clk);
    head0 = sb[0].data;
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ovf0",  32'(overflow), 32'd0);
    chk("bp_head",  32'(out_data), 32'(head0));
    @(negedge clk);
    chk("bp_stable", 32'(out_data), 32'(head0));
    @(posedge clk); #1;
    send_rand(1'b0);
    repeat (4) @(negedge clk);
    chk("bp_ovf1",  32'(overflow), 32'd1);
    chk("bp_head2", 32'(out_data), 32'(head0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_bp");
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a frame
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(1'b1);
    send_rand(1'b0);
    repeat (3) @(negedge clk);
    chk("mid_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    sb.delete();
    idx = 0;
    #1;
    chk("mid_async_valid", 32'(out_valid), 32'd0);
    chk("mid_async_ovf",   32'(overflow), 32'd0);
    chk("mid_async_data",  32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send_rand(1'b1);
    drain("drain_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
